// File: rtl/eth_pcs_params.sv
// Shared 10GBASE-R PCS constants: sync header codes, block geometry and
// the gearbox buffer-count width.
package eth_pcs_params;

    localparam int W_SYNC    = 2;
    localparam int W_PAYLOAD = 64;
    localparam int W_BLK     = W_SYNC + W_PAYLOAD;
    localparam int W_GB_CNT  = 7;

    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;
    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;

    // One 66-bit block; the sync header occupies the earliest-received bits.
    typedef struct packed {
        logic [W_PAYLOAD-1:0] payload;
        logic [W_SYNC-1:0]    sync_hdr;
    } pcs_blk_t;

endpackage

// File: rtl/eth_pcs_rx_gearbox.sv
// RX 32->66 gearbox with one-bit slip for block alignment.
// Optional applied-slip counter port o_slip_cnt under ETH_PCS_RX_GEARBOX_SLIP_CNT_EN.
module eth_pcs_rx_gearbox
    import eth_pcs_params::*;
#(
    parameter int W_IN = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [W_IN-1:0]      i_data,
    input  logic                 i_slip,
    output logic                 o_valid,
    output logic [W_SYNC-1:0]    o_sync_hdr,
    output logic [W_PAYLOAD-1:0] o_data
`ifdef ETH_PCS_RX_GEARBOX_SLIP_CNT_EN
    ,
    output logic [15:0]          o_slip_cnt
`endif
);

    localparam int                  W_BUF   = W_IN + W_BLK;
    localparam logic [W_GB_CNT-1:0] CNT_IN  = W_GB_CNT'(W_IN);
    localparam logic [W_GB_CNT-1:0] CNT_BLK = W_GB_CNT'(W_BLK);
    localparam logic [W_GB_CNT-1:0] CNT_ONE = W_GB_CNT'(1);

    logic [W_BUF-1:0]    r_buf;
    logic [W_GB_CNT-1:0] r_cnt;
    logic                r_slip_pend;
    logic                r_valid;
    pcs_blk_t            r_blk;

    logic [W_BUF-1:0]    w_buf;
    logic [W_GB_CNT-1:0] w_avail;
    logic                w_slip_req;
    logic                w_slip_do;
    logic                w_slip_pend;
    logic                w_extract;
    pcs_blk_t            w_blk;

    assign w_slip_req = (i_slip & r_valid) | r_slip_pend;

    // Bits at and above r_cnt are always zero, so new data can be OR-ed in.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch;
        // blocking assignments let each step see the previous step's result.
        w_buf       = r_buf;
        w_avail     = r_cnt;
        w_slip_do   = 1'b0;
        w_slip_pend = 1'b0;
        w_extract   = 1'b0;
        w_blk       = r_blk;

        if (i_valid) begin
            w_buf   = r_buf | (W_BUF'(i_data) << r_cnt);
            w_avail = r_cnt + CNT_IN;
        end

        if (w_slip_req) begin
            if (w_avail != '0) begin
                w_slip_do = 1'b1;
                w_buf     = w_buf >> 1;
                w_avail   = w_avail - CNT_ONE;
            end else begin
                w_slip_pend = 1'b1;
            end
        end

        if (w_avail >= CNT_BLK) begin
            w_extract = 1'b1;
            w_blk     = pcs_blk_t'(w_buf[W_BLK-1:0]);
            w_buf     = w_buf >> W_BLK;
            w_avail   = w_avail - CNT_BLK;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: the buffer is cleared on reset because the OR-in append relies
        // on unused bits being zero, not merely on r_cnt being zero.
        if (i_reset) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_slip_pend <= 1'b0;
            r_valid     <= 1'b0;
            r_blk       <= '0;
        end else begin
            r_buf       <= w_buf;
            r_cnt       <= w_avail;
            r_slip_pend <= w_slip_pend;
            r_valid     <= w_extract;
            r_blk       <= w_blk;
        end
    end

    assign o_valid    = r_valid;
    assign o_sync_hdr = r_blk.sync_hdr;
    assign o_data     = r_blk.payload;

`ifdef ETH_PCS_RX_GEARBOX_SLIP_CNT_EN
    logic [15:0] r_slip_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slip_cnt <= '0;
        end else if (w_slip_do && (r_slip_cnt != 16'hFFFF)) begin
            r_slip_cnt <= r_slip_cnt + 16'd1;
        end
    end

    assign o_slip_cnt = r_slip_cnt;
`endif

endmodule

// File: doc/eth_pcs_rx_gearbox.md
Name: eth_pcs_rx_gearbox

Overview:
RX 32→66 gearbox for the 10GBASE-R PCS. It sits between the SerDes/PMA parallel interface and eth_pcs_rx_block_synch. It accumulates 32-bit words and emits one 66-bit block (sync header plus 64-bit payload) whenever 66 bits are buffered. It also applies one-bit slips requested by block sync until block lock is reached.

Parameters:
- W_IN, 32, input word width. Supported values are 16 and 32.
- W_BLK, 66, block width, equal to W_SYNC + W_PAYLOAD. Taken from eth_pcs_params and not overridable.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  i_data carries W_IN new bits this cycle.
- i_data  in  W_IN  received bits; bit 0 is the earliest received.
- i_slip  in  1  slip request from block sync. Honoured only while o_valid=1.
- o_valid  out  1  o_sync_hdr and o_data hold a new block this cycle.
- o_sync_hdr  out  W_SYNC  block bits [1:0].
- o_data  out  64  block bits [65:2], unscrambled order preserved.

Behaviour:
- Reset values: o_valid=0, o_sync_hdr=0, o_data=0. Buffer count q_cnt=0, buffer contents 0, q_slip_pend=0.
- Buffer: LSB-first shift buffer of W_IN+W_BLK bits. The oldest bit is at index 0.
- q_cnt range is 0..W_BLK-1+W_IN (7 bits). Before each edge, q_cnt ≤ 65.
- Per rising edge, when not in reset, evaluate in this order:
  1. Append: if i_valid, append i_data above the q_cnt valid bits; avail = q_cnt + W_IN. Otherwise avail = q_cnt.
  2. Slip: slip_req = (i_slip & o_valid) | q_slip_pend.
     - If slip_req and avail ≥ 1: discard the oldest bit, avail -= 1, and clear q_slip_pend.
     - If slip_req and avail = 0: set q_slip_pend.
  3. Extract: if avail ≥ 66, register bits [65:0] to the outputs, shift out 66 bits, set o_valid=1. Otherwise o_valid=0.
  4. Update: q_cnt = remaining count.
- Latency: a block is output one cycle after the edge at which its 66th bit was appended.
- o_sync_hdr and o_data hold their last value while o_valid=0.
- Throughput for W_IN=32 with continuous i_valid: exactly 16 blocks per 33 input words. At most one block per cycle.
- i_slip while o_valid=0 is ignored.
- At most one bit is dropped per edge. q_slip_pend cannot stack: while it is set, no extraction occurs, so o_valid is 0 the next cycle.
- 66 slips return the output to the original alignment.
- i_valid low: nothing is appended. A pending slip is still applied if buffered bits are ≥1.
- Reset mid-operation: all buffered bits and any pending slip are discarded. The first block after reset uses the first 66 bits received after reset deasserts.

Optional Feature:
- Macro ETH_PCS_RX_GEARBOX_SLIP_CNT_EN.
- When defined: adds output port o_slip_cnt [15:0], a count of applied slips.
  - Increments on each edge where a bit is actually discarded.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- eth_pcs_params gains W_BLK=66, W_PAYLOAD=64 and W_GB_CNT=7 (buffer count width).
- W_SYNC, SYNC_CTRL and SYNC_DATA are reused from eth_pcs_params.
- No sub-module is needed; the shift/extract datapath and slip control sit in one always_comb/always_ff pair.
- The top-level RX path instantiates it directly ahead of eth_pcs_rx_block_synch.
  - o_valid drives i_valid.
  - o_sync_hdr drives i_sync_hdr.
  - o_slip drives i_slip.

Test Plan:
- Aligned stream: 33 continuous words built from 16 blocks, each with header 2'b01 and payload 64'h0123_4567_89AB_CDEF. Expect 16 o_valid pulses, each with o_sync_hdr=2'b01 and the exact payload, and the first o_valid one cycle after the 66th bit is appended.
- Slip alignment: the stream is offset by 5 bits. Pulse i_slip on 5 consecutive o_valid cycles, then expect every subsequent block to be correctly aligned with header 01 or 10.
- Pending slip: drive an input word such that extraction leaves avail=0 with i_slip=1, then hold i_valid=0 for 3 cycles. Expect q_slip_pend=1 and no o_valid. The next word drops its bit 0.
- Input gaps: deassert i_valid randomly at about 30%. Expect the block sequence to be identical to the continuous case, o_valid never high on consecutive cycles for W_IN=32, and outputs stable between pulses.
- Full rotation: apply 66 slips to an aligned stream. Expect the final alignment to equal the original. With ETH_PCS_RX_GEARBOX_SLIP_CNT_EN defined, expect o_slip_cnt=66.
- Reset mid-block: assert i_reset with q_cnt=40. Expect o_valid=0 and outputs 0 the next cycle. The first block after reset comes from post-reset bits only.
